// File: rtl/counter_share_sched.sv
// Round-robin scheduler that time-shares one external counter among NREQ requesters.
// Optional abort-on-request-drop behaviour is enabled with `define CNT_SHARE_SCHED_ABORT_EN.
module counter_share_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              cnt_rst,
    output logic              cnt_en,
    input  logic [CW-1:0]     cnt_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   idx_r;
    logic [CW-1:0]   len_r;
    logic [IW-1:0]   win_s;
    logic            req_held_s;
    logic            abort_s;
    logic            run_over_s;

    // First requester at or after the round-robin pointer, wrapping modulo NREQ.
    function automatic logic [IW-1:0] pick_winner(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] w;
        logic          found;
        int unsigned   j;
        w     = p;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(p) + k) % NREQ;
            if (!found && r[j]) begin
                w     = IW'(j);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? {IW{1'b0}} : i + IW'(1);
    endfunction

    function automatic logic [NREQ-1:0] to_onehot(input logic [IW-1:0] i);
        return NREQ'(1) << i;
    endfunction

`ifdef CNT_SHARE_SCHED_ABORT_EN
    assign req_held_s = req[idx_r];
`else
    assign req_held_s = 1'b1;
`endif

    assign win_s      = pick_winner(req, ptr_r);
    assign abort_s    = ((state_r == CLEAR) || (state_r == RUN)) && !req_held_s;
    // >= tolerates an external counter that overshoots the requested length.
    assign run_over_s = (cnt_count >= len_r);
    assign cnt_en     = (state_r == RUN) && !run_over_s && req_held_s;
    assign busy       = (state_r != IDLE);

    // Scheduler FSM with registered grant, done and counter-clear outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            gnt     <= {NREQ{1'b0}};
            done    <= {NREQ{1'b0}};
            cnt_rst <= 1'b0;
            ptr_r   <= {IW{1'b0}};
            idx_r   <= {IW{1'b0}};
            len_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        idx_r   <= win_s;
                        len_r   <= len[int'(win_s)*CW +: CW];
                        gnt     <= to_onehot(win_s);
                        cnt_rst <= 1'b1;
                        state_r <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt_rst <= 1'b0;
                    if (abort_s) begin
                        gnt     <= {NREQ{1'b0}};
                        ptr_r   <= next_idx(idx_r);
                        state_r <= IDLE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (abort_s) begin
                        gnt     <= {NREQ{1'b0}};
                        ptr_r   <= next_idx(idx_r);
                        state_r <= IDLE;
                    end else if (run_over_s) begin
                        done    <= to_onehot(idx_r);
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    gnt     <= {NREQ{1'b0}};
                    done    <= {NREQ{1'b0}};
                    ptr_r   <= next_idx(idx_r);
                    state_r <= IDLE;
                end
                default: begin
                    gnt     <= {NREQ{1'b0}};
                    done    <= {NREQ{1'b0}};
                    cnt_rst <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
